// File: rtl/mem_xfer_pkg.sv
// Shared types and defaults for the L1-to-main-memory request sequencer.
package mem_xfer_pkg;

  localparam int DEF_ADDR_W   = 27;
  localparam int DEF_LINE_W   = 256;
  localparam int DEF_BE_W     = DEF_LINE_W / 8;
  localparam int MM_READ_LAT  = 2;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    MERGE,
    WR_A,
    WR_D
  } state_t;

endpackage

// File: rtl/mem_xfer_ctrl_line_byte_merge.sv
// Combinational per-byte line merge: enabled bytes from new_i, the rest from old_i.
module line_byte_merge
  import mem_xfer_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BE_W   = LINE_W / 8
) (
  input  logic [LINE_W-1:0] old_i,
  input  logic [LINE_W-1:0] new_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [LINE_W-1:0] line_o
);

  always_comb begin
    line_o = old_i;
    for (int i = 0; i < BE_W; i++) begin
      if (be_i[i]) line_o[i*8 +: 8] = new_i[i*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Sequences one line read/write at a time onto the main-memory pin protocol;
// partial writes become read-modify-write, range and read-timeout errors are sticky.
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LINE_W      = DEF_LINE_W,
  parameter int BE_W        = LINE_W / 8,
  parameter int MEM_ENTRIES = 256,
  parameter int RD_TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [LINE_W-1:0] req_wd,
  output logic              rsp_valid,
  output logic [LINE_W-1:0] rsp_rd,
  output logic              wr_done,
  output logic              err,
  output logic [ADDR_W-1:0] mm_a,
  output logic [BE_W-1:0]   mm_be,
  output logic [LINE_W-1:0] mm_wd,
  output logic              mm_write,
  output logic              mm_read,
  input  logic [LINE_W-1:0] mm_rd,
  input  logic              mm_valid
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LAST    = TW'(RD_TIMEOUT - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_ENTRIES);

  state_t            state_q;
  logic [DW-1:0]     drain_cnt_q;
  logic [TW-1:0]     wait_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [LINE_W-1:0] wd_q;
  logic              write_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] merged_d;
  logic [LINE_W-1:0] rd_fill;
  logic              addr_oob;

  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [LINE_W-1:0] rsp_rd_q;
  logic              wr_done_q;
  logic              err_q;
  logic [ADDR_W-1:0] mm_a_q;
  logic [BE_W-1:0]   mm_be_q;
  logic [LINE_W-1:0] mm_wd_q;
  logic              mm_write_q;
  logic              mm_read_q;

  assign addr_oob = {1'b0, req_addr} >= ADDR_LIMIT;
  // A timed-out read behaves as if the line came back all zeros.
  assign rd_fill  = mm_valid ? mm_rd : '0;

  line_byte_merge #(
    .LINE_W (LINE_W),
    .BE_W   (BE_W)
  ) u_merge (
    .old_i  (rdata_q),
    .new_i  (wd_q),
    .be_i   (be_q),
    .line_o (merged_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DRAIN;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wd_q        <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      wr_done_q   <= 1'b0;
      err_q       <= 1'b0;
      mm_a_q      <= '0;
      mm_be_q     <= '0;
      mm_wd_q     <= '0;
      mm_write_q  <= 1'b0;
      mm_read_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      wr_done_q   <= 1'b0;
      case (state_q)
        DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DW'(1);
          end
        end
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            be_q    <= req_be;
            wd_q    <= req_wd;
            write_q <= req_write;
            if (addr_oob) begin
              err_q <= 1'b1;
              if (req_write) wr_done_q <= 1'b1;
              else           rsp_valid_q <= 1'b1;
            end else if (req_write && ~|req_be) begin
              wr_done_q <= 1'b1;
            end else if (req_write && &req_be) begin
              state_q     <= WR_A;
              mm_a_q      <= req_addr;
              req_ready_q <= 1'b0;
            end else begin
              state_q     <= RD_ISSUE;
              mm_a_q      <= req_addr;
              mm_read_q   <= 1'b1;
              req_ready_q <= 1'b0;
            end
          end
        end
        RD_ISSUE: begin
          mm_read_q  <= 1'b0;
          mm_a_q     <= '0;
          wait_cnt_q <= '0;
          state_q    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mm_valid || wait_cnt_q == TO_LAST) begin
            if (!mm_valid) err_q <= 1'b1;
            if (write_q) begin
              rdata_q <= rd_fill;
              state_q <= MERGE;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_rd_q    <= rd_fill;
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end
        MERGE: begin
          // The merged line is written whole, so every byte is enabled.
          wd_q    <= merged_d;
          be_q    <= '1;
          mm_a_q  <= addr_q;
          state_q <= WR_A;
        end
        WR_A: begin
          mm_write_q <= 1'b1;
          mm_wd_q    <= wd_q;
          mm_be_q    <= be_q;
          state_q    <= WR_D;
        end
        WR_D: begin
          mm_write_q  <= 1'b0;
          mm_wd_q     <= '0;
          mm_be_q     <= '0;
          mm_a_q      <= '0;
          wr_done_q   <= 1'b1;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q     <= DRAIN;
          drain_cnt_q <= '0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rd    = rsp_rd_q;
  assign wr_done   = wr_done_q;
  assign err       = err_q;
  assign mm_a      = mm_a_q;
  assign mm_be     = mm_be_q;
  assign mm_wd     = mm_wd_q;
  assign mm_write  = mm_write_q;
  assign mm_read   = mm_read_q;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed bench for mem_xfer_ctrl with a small main-memory model (2-cycle reads,
// writes land on the previous cycle's address).
module tb_mem_xfer_ctrl;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [26:0]  req_addr;
  logic [31:0]  req_be;
  logic [255:0] req_wd;
  logic         rsp_valid;
  logic [255:0] rsp_rd;
  logic         wr_done;
  logic         err;
  logic [26:0]  mm_a;
  logic [31:0]  mm_be;
  logic [255:0] mm_wd;
  logic         mm_write;
  logic         mm_read;
  logic [255:0] mm_rd;
  logic         mm_valid;

  int n_pass = 0;
  int n_total = 0;

  mem_xfer_ctrl #(
    .ADDR_W(27), .LINE_W(256), .BE_W(32), .MEM_ENTRIES(256), .RD_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_be(req_be), .req_wd(req_wd),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .wr_done(wr_done), .err(err),
    .mm_a(mm_a), .mm_be(mm_be), .mm_wd(mm_wd), .mm_write(mm_write), .mm_read(mm_read),
    .mm_rd(mm_rd), .mm_valid(mm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main-memory model ----------------
  logic [255:0] ram [0:255];
  logic [26:0]  a_prev = '0;
  logic         rd_p1 = 1'b0;
  logic [26:0]  rd_a1 = '0;
  logic         mem_hold = 1'b0;
  logic         pl_en = 1'b0;
  logic [7:0]   pl_addr = '0;
  logic [255:0] pl_data = '0;
  logic [255:0] wline;

  always_comb begin
    wline = ram[a_prev[7:0]];
    for (int b = 0; b < 32; b++) begin
      if (mm_be[b]) wline[b*8 +: 8] = mm_wd[b*8 +: 8];
    end
  end

  initial begin
    mm_valid = 1'b0;
    mm_rd    = '0;
  end

  always @(posedge clk) begin
    a_prev <= mm_a;
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mm_write) ram[a_prev[7:0]] <= wline;
    rd_p1    <= mm_read;
    rd_a1    <= mm_a;
    mm_valid <= rd_p1 && !mem_hold;
    mm_rd    <= rd_p1 ? ram[rd_a1[7:0]] : '0;
  end

  // ---------------- helpers (no checking) ----------------
  function automatic logic [255:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input logic [255:0] d);
    pl_en   = 1'b1;
    pl_addr = a[7:0];
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic send(input logic w, input int a, input logic [31:0] be, input logic [255:0] wd);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = 27'(a);
    req_be    = be;
    req_wd    = wd;
  endtask

  // Accepts a read now, returns what the response port shows 4 cycles later.
  task automatic read_line(input int a, output logic v, output logic [255:0] d);
    send(1'b0, a, '0, '0);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    v = rsp_valid;
    d = rsp_rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(); tick();
    n_total++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else n_pass++;
    n_total++; if ({rsp_valid, wr_done, err, mm_read, mm_write} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {rsp_valid, wr_done, err, mm_read, mm_write}); else n_pass++;
    n_total++; if ((|{mm_a, mm_be, mm_wd, rsp_rd}) !== 1'b0)
      $display("FAIL reset_buses: got %b want 0", |{mm_a, mm_be, mm_wd, rsp_rd}); else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_total++; if (req_ready !== 1'b0) $display("FAIL drain_ready c%0d: got %b want 0", c, req_ready); else n_pass++;
      tick();
    end
    n_total++; if (req_ready !== 1'b1) $display("FAIL drain_exit_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_full_write();
    logic [255:0] la5;
    la5 = {32{8'hA5}};
    send(1'b1, 5, 32'hFFFF_FFFF, la5);
    tick();
    req_valid = 1'b0;
    n_total++; if ({mm_write, mm_a, req_ready} !== {1'b0, 27'd5, 1'b0})
      $display("FAIL wr_a: got we=%b a=%0d rdy=%b want we=0 a=5 rdy=0", mm_write, mm_a, req_ready); else n_pass++;
    tick();
    n_total++; if ({mm_write, mm_a, mm_be} !== {1'b1, 27'd5, 32'hFFFF_FFFF})
      $display("FAIL wr_d: got we=%b a=%0d be=%h want we=1 a=5 be=ffffffff", mm_write, mm_a, mm_be); else n_pass++;
    n_total++; if (mm_wd !== la5) $display("FAIL wr_d_data: got %h want %h", mm_wd, la5); else n_pass++;
    tick();
    n_total++; if ({wr_done, req_ready, mm_write} !== 3'b110)
      $display("FAIL wr_done: got done=%b rdy=%b we=%b want 1 1 0", wr_done, req_ready, mm_write); else n_pass++;
    send(1'b0, 5, '0, '0);
    tick();
    req_valid = 1'b0;
    n_total++; if ({mm_read, mm_a} !== {1'b1, 27'd5})
      $display("FAIL rd_issue: got rd=%b a=%0d want rd=1 a=5", mm_read, mm_a); else n_pass++;
    tick(); tick();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rd_early_rsp: got %b want 0", rsp_valid); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, req_ready} !== 2'b11)
      $display("FAIL rd_rsp_valid: got v=%b rdy=%b want 1 1", rsp_valid, req_ready); else n_pass++;
    n_total++; if (rsp_rd !== la5) $display("FAIL rd_rsp_data: got %h want %h", rsp_rd, la5); else n_pass++;
  endtask

  task automatic test_rmw();
    int rsp_cnt;
    logic v;
    logic [255:0] d;
    logic [255:0] exp_line;
    exp_line = {{31{8'h11}}, 8'hFF};
    rsp_cnt = 0;
    send(1'b1, 3, 32'h0000_0001, {248'h0, 8'hFF});
    tick();
    req_valid = 1'b0;
    n_total++; if ({mm_read, mm_write, mm_a} !== {1'b1, 1'b0, 27'd3})
      $display("FAIL rmw_read: got rd=%b we=%b a=%0d want 1 0 3", mm_read, mm_write, mm_a); else n_pass++;
    for (int c = 2; c <= 4; c++) begin
      tick();
      rsp_cnt += int'(rsp_valid);
    end
    tick();
    rsp_cnt += int'(rsp_valid);
    n_total++; if ({mm_write, mm_a} !== {1'b0, 27'd3})
      $display("FAIL rmw_wr_a: got we=%b a=%0d want 0 3", mm_write, mm_a); else n_pass++;
    tick();
    rsp_cnt += int'(rsp_valid);
    n_total++; if ({mm_write, wr_done} !== 2'b10)
      $display("FAIL rmw_wr_d: got we=%b done=%b want 1 0", mm_write, wr_done); else n_pass++;
    n_total++; if (mm_wd !== exp_line) $display("FAIL rmw_merge: got %h want %h", mm_wd, exp_line); else n_pass++;
    tick();
    rsp_cnt += int'(rsp_valid);
    n_total++; if (wr_done !== 1'b1) $display("FAIL rmw_done: got %b want 1", wr_done); else n_pass++;
    n_total++; if (rsp_cnt !== 0) $display("FAIL rmw_no_rsp: got %0d pulses want 0", rsp_cnt); else n_pass++;
    read_line(3, v, d);
    n_total++; if (v !== 1'b1 || d !== exp_line)
      $display("FAIL rmw_readback: got v=%b %h want 1 %h", v, d, exp_line); else n_pass++;
  endtask

  task automatic test_be_zero();
    send(1'b1, 4, 32'h0, '1);
    tick();
    req_valid = 1'b0;
    n_total++; if ({wr_done, mm_write, mm_read, req_ready} !== 4'b1001)
      $display("FAIL be0_done: got done=%b we=%b rd=%b rdy=%b want 1 0 0 1", wr_done, mm_write, mm_read, req_ready); else n_pass++;
    tick();
    n_total++; if ({wr_done, mm_write} !== 2'b00)
      $display("FAIL be0_single: got done=%b we=%b want 0 0", wr_done, mm_write); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rd_cyc [8];
    int n_rd;
    int n_rsp;
    int nxt;
    logic acc;
    n_rd = 0; n_rsp = 0; nxt = 0;
    for (int i = 0; i < 8; i++) rd_cyc[i] = 0;
    send(1'b0, 10, '0, '0);
    for (int c = 1; c <= 20; c++) begin
      acc = req_valid && req_ready;
      tick();
      if (acc) begin
        nxt++;
        if (nxt == 4) req_valid = 1'b0;
        else req_addr = 27'(10 + nxt);
      end
      if (mm_read) begin
        if (n_rd < 8) rd_cyc[n_rd] = c;
        n_rd++;
      end
      if (rsp_valid) begin
        n_total++; if (rsp_rd !== pat(10 + n_rsp))
          $display("FAIL b2b_data%0d: got %h want %h", n_rsp, rsp_rd, pat(10 + n_rsp)); else n_pass++;
        n_rsp++;
      end
    end
    n_total++; if (n_rd !== 4) $display("FAIL b2b_read_cycles: got %0d want 4", n_rd); else n_pass++;
    n_total++; if (n_rsp !== 4) $display("FAIL b2b_rsp_count: got %0d want 4", n_rsp); else n_pass++;
    n_total++; if (rd_cyc[0] !== 1) $display("FAIL b2b_first_read: got cycle %0d want 1", rd_cyc[0]); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      n_total++; if (rd_cyc[k] - rd_cyc[k-1] !== 4)
        $display("FAIL b2b_gap%0d: got %0d want 4", k, rd_cyc[k] - rd_cyc[k-1]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int rsp_cnt;
    logic v;
    logic [255:0] d;
    rsp_cnt = 0;
    send(1'b0, 2, '0, '0);
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_total++; if ({mm_read, req_ready, rsp_valid} !== 3'b000)
      $display("FAIL midrst_outputs: got rd=%b rdy=%b v=%b want 0 0 0", mm_read, req_ready, rsp_valid); else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_total++; if (req_ready !== 1'b0) $display("FAIL midrst_drain c%0d: got %b want 0", c, req_ready); else n_pass++;
      tick();
      rsp_cnt += int'(rsp_valid);
    end
    n_total++; if (req_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", req_ready); else n_pass++;
    n_total++; if (rsp_cnt !== 0) $display("FAIL midrst_stale: got %0d pulses want 0", rsp_cnt); else n_pass++;
    read_line(2, v, d);
    n_total++; if (v !== 1'b1 || d !== pat(2))
      $display("FAIL midrst_read: got v=%b %h want 1 %h", v, d, pat(2)); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL midrst_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_timeout();
    int rsp_cnt;
    rsp_cnt = 0;
    mem_hold = 1'b1;
    send(1'b0, 7, '0, '0);
    tick();
    req_valid = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      tick();
      rsp_cnt += int'(rsp_valid);
    end
    n_total++; if ({err, rsp_cnt != 0} !== 2'b00)
      $display("FAIL to_early: got err=%b pulses=%0d want 0 0", err, rsp_cnt); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, err, req_ready} !== 3'b111)
      $display("FAIL to_flags: got v=%b err=%b rdy=%b want 1 1 1", rsp_valid, err, req_ready); else n_pass++;
    n_total++; if (rsp_rd !== '0) $display("FAIL to_data: got %h want 0", rsp_rd); else n_pass++;
    mem_hold = 1'b0;
    tick();
  endtask

  task automatic test_range();
    logic v;
    logic [255:0] d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    n_total++; if ({err, req_ready} !== 2'b01)
      $display("FAIL range_pre: got err=%b rdy=%b want 0 1", err, req_ready); else n_pass++;
    send(1'b0, 300, '0, '0);
    tick();
    req_valid = 1'b0;
    n_total++; if ({rsp_valid, err, mm_read} !== 3'b110)
      $display("FAIL range_rd: got v=%b err=%b rd=%b want 1 1 0", rsp_valid, err, mm_read); else n_pass++;
    n_total++; if (rsp_rd !== '0) $display("FAIL range_rd_data: got %h want 0", rsp_rd); else n_pass++;
    tick();
    n_total++; if ({mm_read, rsp_valid} !== 2'b00)
      $display("FAIL range_no_op: got rd=%b v=%b want 0 0", mm_read, rsp_valid); else n_pass++;
    send(1'b1, 1000, 32'hFFFF_FFFF, '1);
    tick();
    req_valid = 1'b0;
    n_total++; if ({wr_done, req_ready, mm_write} !== 3'b110)
      $display("FAIL range_wr: got done=%b rdy=%b we=%b want 1 1 0", wr_done, req_ready, mm_write); else n_pass++;
    tick();
    read_line(5, v, d);
    n_total++; if (v !== 1'b1 || d !== {32{8'hA5}})
      $display("FAIL range_good_read: got v=%b %h", v, d); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL range_sticky: got %b want 1", err); else n_pass++;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wd    = '0;
    #1 rst = 1'b1;
    preload(2, pat(2));
    preload(3, {32{8'h11}});
    for (int i = 10; i < 14; i++) preload(i, pat(i));
    test_reset();
    test_full_write();
    test_rmw();
    test_be_zero();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_range();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_xfer_ctrl.md
# mem_xfer_ctrl

Request sequencer between the L1 cache controller and `mainmemory`. Accepts one line-granular read (fill) or write (evict/store-through) request at a time over a valid/ready port, and converts it to the main-memory pin protocol: 2-cycle read latency, one-cycle-delayed write address, at least one idle cycle between reads. Partial-byte-enable writes become read-modify-write, because main memory commits whole lines only. Also enforces the main-memory address range and a read-response timeout.

## Interface
- ADDR_W, 27, line address width
- LINE_W, 256, line data width
- BE_W, 32, byte enables (LINE_W/8)
- MEM_ENTRIES, 256, valid line addresses 0..MEM_ENTRIES-1
- RD_TIMEOUT, 8, cycles in RD_WAIT before a missing `mm_valid` is declared an error
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on cycles where valid&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  line address
- req_be  in  BE_W  byte enables (write only)
- req_wd  in  LINE_W  write data
- rsp_valid  out  1  one-cycle pulse, read complete
- rsp_rd  out  LINE_W  read data, valid with rsp_valid, else 0
- wr_done  out  1  one-cycle pulse, write committed
- err  out  1  sticky error (range or timeout), cleared only by rst
- mm_a, mm_be, mm_wd, mm_write, mm_read  out  to main memory (ADDR_W, BE_W, LINE_W, 1, 1)
- mm_rd  in  LINE_W, mm_valid  in  1  from main memory

## Operation
- States: DRAIN, IDLE, RD_ISSUE, RD_WAIT, MERGE, WR_A, WR_D.
- Reset enters DRAIN. All outputs are 0; err is cleared. DRAIN lasts 3 cycles so that a main-memory read in flight before reset is discarded, then goes to IDLE.
- req_ready = (state==IDLE). Request fields (addr, be, wd, write) are latched on accept.
- Range check on accept: addr >= MEM_ENTRIES sets err and issues no memory op. The request still completes: rsp_valid with rsp_rd=0 for a read, wr_done for a write. The pulse comes the cycle after accept.
- Read: IDLE→RD_ISSUE. RD_ISSUE drives mm_a=addr and mm_read=1 for exactly one cycle, then →RD_WAIT. In RD_WAIT, mm_valid captures mm_rd and goes →IDLE, with rsp_valid/rsp_rd registered the next cycle.
- Full write (be all ones): IDLE→WR_A→WR_D→IDLE.
  - WR_A drives mm_a=addr, mm_write=0.
  - WR_D holds mm_a, drives mm_write=1, mm_wd=data, mm_be=be.
  - mm_write must never be 1 in WR_A: main memory writes to the previous cycle's address.
  - wr_done pulses the cycle after WR_D.
- Partial write (be not all ones, not zero): RD_ISSUE→RD_WAIT→MERGE→WR_A→WR_D.
  - MERGE forms line[i] = be[i] ? wd byte i : read byte i.
  - No rsp_valid for the internal read; wr_done only.
- be==0 write: no memory op; wr_done the cycle after accept.
- Timeout: RD_WAIT counter reaches RD_TIMEOUT with no mm_valid → err=1, treated as if zero data was read.
  - Plain read: rsp_valid with rsp_rd=0.
  - RMW: merge proceeds with zero data and the write is performed.
- mm_valid outside RD_WAIT is ignored.
- mm_* outputs are 0 when not driven by the states above.

## Timing
- All outputs are registered.
- Read accepted at cycle N:
  - mm_read high in N+1.
  - mm_valid expected in N+3.
  - rsp_valid in N+4.
  - req_ready high again in N+4.
- Full write accepted at N:
  - WR_A at N+1, WR_D at N+2.
  - wr_done and req_ready at N+3.
- RMW accepted at N: mm_read N+1, mm_valid N+3, MERGE N+4, WR_A N+5, WR_D N+6, wr_done N+7.
- Back-to-back reads are spaced ≥3 cycles apart in mm_read, which satisfies main memory's read_q suppression.
- Async rst asserted mid-operation: outputs drop to 0 immediately, and any partial write in WR_A is abandoned. If rst lands in the WR_D cycle, the write may or may not be committed; the bench must not check that line.

## Structure
- Package `mem_xfer_pkg`: state enum; ADDR_W, LINE_W, BE_W defaults; MM_READ_LAT=2; DRAIN_CYCLES=3.
- Sub-module `line_byte_merge`: combinational per-byte merge of LINE_W data under BE_W enables. Instantiated once for the MERGE state.

## Test plan
- Full write addr 5, wd = 256'hA5.., be all ones; then read addr 5 → wr_done at N+3; mm_write high only in WR_D with mm_a=5; rsp_rd=A5.. at read N+4.
- Preload addr 3 with all 0x11; write be=32'h0000_0001, wd byte0=0xFF → mm_read then mm_write; line reads back 0x11..11FF; no rsp_valid; wr_done at N+7.
- Read addr 300 (MEM_ENTRIES=256) → no mm_read; err=1; rsp_valid with rsp_rd=0 at N+1; err stays high through later good ops.
- Memory model holds mm_valid low; read addr 7 → err set after RD_TIMEOUT=8 wait cycles; rsp_valid with rsp_rd=0.
- Four back-to-back reads with req_valid held high → mm_read pulses are single-cycle and 4 cycles apart; every response matches memory contents.
- Assert rst in RD_WAIT; release, then read addr 2 → req_ready low for 3 cycles; stale mm_valid not reported; rsp_rd = ram[2].
